mq_ctx_ctrl: RTL and testbench
==============================

MQ_CTX_CTRL -- requirements
Module: mq_ctx_ctrl

Interface
REQ-001 Parameter NUM_CTX, default 19, number of coding contexts held in the context state table.
REQ-002 Parameter IDX_W, default 6, width of a probability-state (Qe) index.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  single-cycle pulse; re-initialises all contexts (new code block).
REQ-007 init_done  out  1  high when the table is initialised and symbols are accepted.
REQ-008 in_valid  in  1  symbol request valid.
REQ-009 in_ready  out  1  block accepts a symbol this cycle.
REQ-010 in_cx  in  5  context number, 0..NUM_CTX-1.
REQ-011 in_d  in  1  decision bit to code.
REQ-012 out_valid  out  1  issued symbol valid toward the probability-estimation stage.
REQ-013 out_ready  in  1  downstream accepts the issued symbol.
REQ-014 out_d, out_mps  out  1 each  decision and context MPS for the issued symbol.
REQ-015 out_qeindex  out  IDX_W  context Qe index for the issued symbol.
REQ-016 out_forward  out  1  downstream uses the update-stage index/MPS instead of out_qeindex/out_mps.
REQ-017 upd_valid  in  1  update write from the index-update stage.
REQ-018 upd_cx  in  5  context being updated.
REQ-019 upd_index, upd_mps  in  IDX_W, 1  new Qe index and MPS for upd_cx.

Function
REQ-020 FSM states: INIT and RUN; rst or start forces INIT with init pointer 0.
REQ-021 INIT writes one entry per cycle, pointer 0..NUM_CTX-1, then enters RUN: 19 cycles for the default.
REQ-022 Initial entries: cx 0 -> index 4; cx 17 -> index 3; cx 18 -> index 46; all others -> index 0; MPS 0 for every context.
REQ-023 init_done is 1 only in RUN; in_ready is 0 in INIT.
REQ-024 in_ready = RUN and (not out_valid or out_ready).
REQ-025 An accept (in_valid and in_ready) registers the symbol; out_* is valid the next cycle (latency 1).
REQ-026 Without an accept, out_valid is cleared when out_ready is high; otherwise out_* is held stable.
REQ-027 Read data is table[in_cx], except that upd_valid with upd_cx == in_cx in the same cycle bypasses upd_index/upd_mps.
REQ-028 upd_valid writes {upd_index, upd_mps} to table[upd_cx] in RUN; it is ignored in INIT.
REQ-029 A pending flag and pending_cx are set on every accept and cleared on upd_valid.
REQ-030 out_forward = 1 when, at accept, pending is 1 and pending_cx == in_cx and upd_valid is 0; otherwise out_forward = 0.
REQ-031 An in_cx or upd_cx >= NUM_CTX is ignored: no write occurs, and a read returns index 0 with MPS 0.
REQ-032 start in RUN clears out_valid and pending in the same edge; any in-flight symbol is discarded.

Reset
REQ-033 Reset values: out_valid, out_forward, out_d, out_mps, out_qeindex, init_done, in_ready, and pending are all 0; the FSM is in INIT.
REQ-034 Table contents after reset are rewritten by INIT, so the table array needs no reset.

Configuration
REQ-035 MQ_CTX_STATS_EN defined adds two outputs: sym_cnt (32 bits, accepted symbols) and fwd_cnt (32 bits, accepts with out_forward = 1).
REQ-036 Both counters clear on rst and on start, and saturate at all-ones.
REQ-037 With MQ_CTX_STATS_EN undefined, the ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-038 The shared package mq_pkg holds NUM_CTX, IDX_W, the context-number constants 0, 17, and 18 with their initial indices 4, 3, and 46, and the FSM state typedef.
REQ-039 Sub-module mq_ctx_ram: NUM_CTX x (IDX_W+1) storage with one asynchronous read port, one write port, and write-first bypass.

Verification
REQ-040 Reset, then run: init_done rises exactly 19 cycles after rst deasserts; reads return cx0=4/0, cx17=3/0, cx18=46/0, cx5=0/0.
REQ-041 Accept cx3, d=1 with out_ready=1: the next cycle gives out_valid=1, out_qeindex=0, out_mps=0, out_forward=0.
REQ-042 Accept cx7 twice back-to-back with no upd_valid: the second issue gives out_forward=1; a different cx gives 0.
REQ-043 upd_valid cx9 -> index 14, MPS 1, in the same cycle as an accept of cx9: the output gives 14/1 with out_forward=0.
REQ-044 Hold out_ready=0 for 5 cycles: out_* stays stable and in_ready=0; releasing out_ready resumes throughput of 1 symbol per cycle.
REQ-045 Pulse start while out_valid=1: out_valid=0 the next cycle, the FSM is in INIT, and the 19-cycle re-initialisation restores cx0 to index 4.

Source files
------------

// File: rtl/mq_pkg.sv
// Shared constants and types for the MQ context-state controller.
// Holds table geometry, the non-zero initial context entries and FSM states.
package mq_pkg;

    localparam int NUM_CTX = 19;
    localparam int IDX_W   = 6;
    localparam int CX_W    = 5;

    // Contexts that do not start at Qe index 0
    localparam int CX_ZC0  = 0;
    localparam int IDX_ZC0 = 4;
    localparam int CX_RL   = 17;
    localparam int IDX_RL  = 3;
    localparam int CX_UNI  = 18;
    localparam int IDX_UNI = 46;

    typedef logic [0:0] state_t;

    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/mq_ctx_ram.sv
// Context state storage: DEPTH x DW, one async read port, one write port.
// A read of the address being written returns the write data (write-first).
// Out-of-range addresses never write and read as zero.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module mq_ctx_ram #(
    parameter int DEPTH = 19,
    parameter int DW    = 7,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    import mq_pkg::*;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];

    logic w_ok;
    logic r_ok;

    assign w_ok = we_i && ({1'b0, waddr_i} < DEPTH_W);
    assign r_ok = {1'b0, raddr_i} < DEPTH_W;

    always_ff @(posedge clk_i) begin
        if (w_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (r_ok) begin
            if (w_ok && (waddr_i == raddr_i)) begin
                rdata_o = wdata_i;
            end else begin
                rdata_o = mem_q[raddr_i];
            end
        end
    end

endmodule

// File: rtl/mq_ctx_ctrl.sv
// MQ coder context controller: initialises the context table, issues
// symbols with their context state, and takes index/MPS updates back.
// Ports: clk, rst, start, init_done; in_* symbol request (valid/ready);
// out_* issued symbol (valid/ready) with out_forward hazard flag;
// upd_* table write-back. Define MQ_CTX_STATS_EN to add sym_cnt/fwd_cnt.
module mq_ctx_ctrl #(
    parameter int NUM_CTX = mq_pkg::NUM_CTX,
    parameter int IDX_W   = mq_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             init_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_cx,
    input  logic             in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_d,
    output logic             out_mps,
    output logic [IDX_W-1:0] out_qeindex,
    output logic             out_forward,
    input  logic             upd_valid,
    input  logic [4:0]       upd_cx,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_mps
`ifdef MQ_CTX_STATS_EN
    ,
    output logic [31:0]      sym_cnt,
    output logic [31:0]      fwd_cnt
`endif
);
    import mq_pkg::*;

    localparam int DW = IDX_W + 1;
    localparam logic [CX_W-1:0] LAST_CX = CX_W'(NUM_CTX - 1);

    state_t           state_q, state_d;
    logic [CX_W-1:0]  ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic             out_d_q, out_d_d;
    logic             out_mps_q, out_mps_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_fwd_q, out_fwd_d;
    logic             pend_q, pend_d;
    logic [CX_W-1:0]  pend_cx_q, pend_cx_d;

    logic             run;
    logic             accept;
    logic             fwd_hit;
    logic [IDX_W-1:0] init_idx;
    logic             ram_we;
    logic [CX_W-1:0]  ram_waddr;
    logic [DW-1:0]    ram_wdata;
    logic [DW-1:0]    ram_rdata;

    assign run       = (state_q == ST_RUN);
    assign init_done = run;
    assign in_ready  = run && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;

    assign out_valid   = out_valid_q;
    assign out_d       = out_d_q;
    assign out_mps     = out_mps_q;
    assign out_qeindex = out_idx_q;
    assign out_forward = out_fwd_q;

    // Previous symbol's update has not come back yet for the same context
    assign fwd_hit = pend_q && (pend_cx_q == in_cx) && !upd_valid;

    always_comb begin
        init_idx = '0;
        case (ptr_q)
            CX_W'(CX_ZC0): init_idx = IDX_W'(IDX_ZC0);
            CX_W'(CX_RL):  init_idx = IDX_W'(IDX_RL);
            CX_W'(CX_UNI): init_idx = IDX_W'(IDX_UNI);
            default:       init_idx = '0;
        endcase
    end

    // INIT owns the write port; in RUN it carries the update stage
    always_comb begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = {init_idx, 1'b0};
        if (run) begin
            ram_we    = upd_valid;
            ram_waddr = upd_cx;
            ram_wdata = {upd_index, upd_mps};
        end
    end

    mq_ctx_ram #(
        .DEPTH (NUM_CTX),
        .DW    (DW),
        .AW    (CX_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (in_cx),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_d_d     = out_d_q;
        out_mps_d   = out_mps_q;
        out_idx_d   = out_idx_q;
        out_fwd_d   = out_fwd_q;
        pend_d      = pend_q;
        pend_cx_d   = pend_cx_q;
        if (start) begin
            state_d     = ST_INIT;
            ptr_d       = '0;
            out_valid_d = 1'b0;
            pend_d      = 1'b0;
        end else begin
            if (!run) begin
                if (ptr_q == LAST_CX) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + CX_W'(1);
                end
            end
            if (upd_valid) begin
                pend_d = 1'b0;
            end
            // A new accept outranks the clear: its own update is now owed
            if (accept) begin
                out_valid_d = 1'b1;
                out_d_d     = in_d;
                out_mps_d   = ram_rdata[0];
                out_idx_d   = ram_rdata[DW-1:1];
                out_fwd_d   = fwd_hit;
                pend_d      = 1'b1;
                pend_cx_d   = in_cx;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_d_q     <= 1'b0;
            out_mps_q   <= 1'b0;
            out_idx_q   <= '0;
            out_fwd_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_cx_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_d_q     <= out_d_d;
            out_mps_q   <= out_mps_d;
            out_idx_q   <= out_idx_d;
            out_fwd_q   <= out_fwd_d;
            pend_q      <= pend_d;
            pend_cx_q   <= pend_cx_d;
        end
    end

`ifdef MQ_CTX_STATS_EN
    logic [31:0] sym_q, sym_d;
    logic [31:0] fwd_q, fwd_d;

    always_comb begin
        sym_d = sym_q;
        fwd_d = fwd_q;
        if (start) begin
            sym_d = '0;
            fwd_d = '0;
        end else if (accept) begin
            if (sym_q != '1) begin
                sym_d = sym_q + 32'd1;
            end
            if (fwd_hit && (fwd_q != '1)) begin
                fwd_d = fwd_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_q <= '0;
            fwd_q <= '0;
        end else begin
            sym_q <= sym_d;
            fwd_q <= fwd_d;
        end
    end

    assign sym_cnt = sym_q;
    assign fwd_cnt = fwd_q;
`endif

endmodule

// File: tb/tb_mq_ctx_ctrl.sv
// Bench for mq_ctx_ctrl: directed symbols, queued expectations,
// and a monitor that checks every completed output handshake.
module tb_mq_ctx_ctrl;

    typedef struct packed {
        logic       d;
        logic       mps;
        logic [5:0] idx;
        logic       fwd;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       init_done;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_cx;
    logic       in_d;
    logic       out_valid;
    logic       out_ready;
    logic       out_d;
    logic       out_mps;
    logic [5:0] out_qeindex;
    logic       out_forward;
    logic       upd_valid;
    logic [4:0] upd_cx;
    logic [5:0] upd_index;
    logic       upd_mps;
`ifdef MQ_CTX_STATS_EN
    logic [31:0] sym_cnt;
    logic [31:0] fwd_cnt;
`endif

    int total = 0;
    int bad   = 0;
    exp_t q[$];

    mq_ctx_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .init_done   (init_done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cx       (in_cx),
        .in_d        (in_d),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_d       (out_d),
        .out_mps     (out_mps),
        .out_qeindex (out_qeindex),
        .out_forward (out_forward),
        .upd_valid   (upd_valid),
        .upd_cx      (upd_cx),
        .upd_index   (upd_index),
        .upd_mps     (upd_mps)
`ifdef MQ_CTX_STATS_EN
        ,
        .sym_cnt     (sym_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per completed output handshake
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            got = {out_d, out_mps, out_qeindex, out_forward};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out got d/mps/idx/fwd=%0d/%0d/%0d/%0d",
                         got.d, got.mps, got.idx, got.fwd);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL out_sym got d/mps/idx/fwd=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                             got.d, got.mps, got.idx, got.fwd,
                             e.d, e.mps, e.idx, e.fwd);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept
    task automatic send(input logic [4:0] cx, input logic d,
                        input logic uv, input logic [4:0] ucx,
                        input logic [5:0] uidx, input logic um,
                        input logic [5:0] eidx, input logic emps,
                        input logic efwd);
        bit ok;
        ok = 1'b0;
        in_valid  = 1'b1;
        in_cx     = cx;
        in_d      = d;
        upd_valid = uv;
        upd_cx    = ucx;
        upd_index = uidx;
        upd_mps   = um;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout cx=%0d got in_ready=0 want 1", cx);
        end else begin
            q.push_back({d, emps, eidx, efwd});
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic sym(input logic [4:0] cx, input logic d,
                       input logic [5:0] eidx, input logic emps,
                       input logic efwd);
        send(cx, d, 1'b0, 5'd0, 6'd0, 1'b0, eidx, emps, efwd);
    endtask

    task automatic upd_only(input logic [4:0] cx, input logic [5:0] idx,
                            input logic m);
        upd_valid = 1'b1;
        upd_cx    = cx;
        upd_index = idx;
        upd_mps   = m;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    // Called at posedge+1 just after the edge that starts INIT
    task automatic count_init(input string name);
        int cyc;
        cyc = 0;
        check({name, "_ready_in_init"}, int'(in_ready), 0);
        while (!init_done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(name, cyc, 19);
    endtask

    initial begin
        time t0;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_cx     = '0;
        in_d      = 1'b0;
        out_ready = 1'b1;
        upd_valid = 1'b0;
        upd_cx    = '0;
        upd_index = '0;
        upd_mps   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_fields",
              int'({out_d, out_mps, out_qeindex, out_forward}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_init("init_cycles");

        // Initial table contents
        sym(5'd0, 1'b0, 6'd4, 1'b0, 1'b0);
        sym(5'd17, 1'b1, 6'd3, 1'b0, 1'b0);
        sym(5'd18, 1'b0, 6'd46, 1'b0, 1'b0);
        sym(5'd5, 1'b1, 6'd0, 1'b0, 1'b0);

        // Plain symbol
        sym(5'd3, 1'b1, 6'd0, 1'b0, 1'b0);

        // Same context back-to-back forwards; different context does not
        sym(5'd7, 1'b0, 6'd0, 1'b0, 1'b0);
        sym(5'd7, 1'b1, 6'd0, 1'b0, 1'b1);
        sym(5'd8, 1'b0, 6'd0, 1'b0, 1'b0);

        // Same-cycle update bypass, then stored value with forward
        send(5'd9, 1'b1, 1'b1, 5'd9, 6'd14, 1'b1, 6'd14, 1'b1, 1'b0);
        sym(5'd9, 1'b0, 6'd14, 1'b1, 1'b1);

        // Out-of-range read and out-of-range update
        sym(5'd25, 1'b1, 6'd0, 1'b0, 1'b0);
        send(5'd20, 1'b0, 1'b1, 5'd20, 6'd33, 1'b1, 6'd0, 1'b0, 1'b0);

        // Standalone update then read
        upd_only(5'd2, 6'd21, 1'b1);
        sym(5'd2, 1'b1, 6'd21, 1'b1, 1'b0);

        // Backpressure: hold for 5 cycles with a request waiting
        sym(5'd0, 1'b1, 6'd4, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cx     = 5'd17;
        in_d      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold",
                  int'({out_valid, in_ready, out_d, out_mps,
                        out_qeindex, out_forward}),
                  int'({1'b1, 1'b0, 1'b1, 1'b0, 6'd4, 1'b0}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        t0 = $time;
        sym(5'd17, 1'b0, 6'd3, 1'b0, 1'b0);
        sym(5'd18, 1'b1, 6'd46, 1'b0, 1'b0);
        sym(5'd0, 1'b0, 6'd4, 1'b0, 1'b0);
        check("throughput_time", int'($time - t0), 30);

        // Restart while a symbol is held
        upd_only(5'd0, 6'd30, 1'b1);
        sym(5'd0, 1'b1, 6'd30, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cx     = 5'd5;
        in_d      = 1'b1;
        @(negedge clk);
        check("pre_start_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_start_valid", int'(out_valid), 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_clears_valid", int'(out_valid), 0);
        check("start_init_done", int'(init_done), 0);
        out_ready = 1'b1;
        count_init("reinit_cycles");
        sym(5'd5, 1'b0, 6'd0, 1'b0, 1'b0);
        sym(5'd0, 1'b0, 6'd4, 1'b0, 1'b0);
        sym(5'd9, 1'b1, 6'd0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
